ysyx_24090012_ifu: RTL and testbench

YSYX_24090012_IFU -- requirements
Module: ysyx_24090012_ifu

---
 rtl/ysyx_24090012_ifu.sv | 130 +++++++++++++
 tb/tb_ysyx_24090012_ifu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090012_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM (REQ/WAIT/HOLD/FLUSH) with redirect handling.
// Optional perf counters (fetch_cnt, flush_cnt) enabled by YSYX_24090012_IFU_PERF_EN.
module ysyx_24090012_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef YSYX_24090012_IFU_PERF_EN
  ,
  output logic [63:0] fetch_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FLUSH} state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        req_valid_q;
  logic        out_valid_q;
  logic [31:0] out_inst_q;
  logic [31:0] out_pc_q;
  logic        out_fault_q;
  logic [31:0] rdr_pc;

  assign rdr_pc         = {redirect_pc[31:2], 2'b00};
  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign out_valid      = out_valid_q;
  assign out_inst       = out_inst_q;
  assign out_pc         = out_pc_q;
  assign out_fault      = out_fault_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_REQ;
      pc_q        <= {RESET_PC[31:2], 2'b00};
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_pc_q    <= 32'h0;
      out_fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          // An accepted request must still be drained even if the target changed.
          if (req_valid_q && imem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= redirect_valid ? S_FLUSH : S_WAIT;
          end else begin
            req_valid_q <= 1'b1;
          end
          if (redirect_valid) pc_q <= rdr_pc;
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_q <= rdr_pc;
            if (imem_rsp_valid) begin
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
            end else begin
              state_q <= S_FLUSH;
            end
          end else if (imem_rsp_valid) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= imem_rsp_err ? NOP : imem_rsp_data;
            out_pc_q    <= pc_q;
            out_fault_q <= imem_rsp_err;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect_valid || out_ready) begin
            pc_q        <= redirect_valid ? rdr_pc : pc_q + 32'd4;
            out_valid_q <= 1'b0;
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_FLUSH: begin
          if (redirect_valid) pc_q <= rdr_pc;
          if (imem_rsp_valid) begin
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

`ifdef YSYX_24090012_IFU_PERF_EN
  logic [63:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        hs;
  logic        disc;

  assign hs        = out_valid_q && out_ready;
  assign disc      = imem_rsp_valid &&
                     ((state_q == S_WAIT && redirect_valid) || state_q == S_FLUSH);
  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= 64'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (hs)   fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if (disc) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24090012_ifu.sv
// Directed bench for ysyx_24090012_ifu: hand-driven memory handshakes, redirects, stalls, faults, reset.
module tb_ysyx_24090012_ifu;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
`ifdef YSYX_24090012_IFU_PERF_EN
  logic [63:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ysyx_24090012_ifu dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_fault(out_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef YSYX_24090012_IFU_PERF_EN
    , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic err);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
  endtask

  // Zero-wait fetch: accept, respond next cycle, consume on the cycle out_valid appears.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input logic err);
    logic [31:0] nxt;
    logic [31:0] exp_inst;
    nxt      = pc + 32'd4;
    exp_inst = err ? 32'h0000_0013 : data;
    chk("req_valid", imem_req_valid, 1);
    chk("req_addr", imem_req_addr, pc);
    issue();
    chk("wait_noreq", imem_req_valid, 0);
    chk("wait_noout", out_valid, 0);
    respond(data, err);
    chk("hold_valid", out_valid, 1);
    chk("out_pc", out_pc, pc);
    chk("out_inst", out_inst, exp_inst);
    chk("out_fault", out_fault, err);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_drop", out_valid, 0);
    chk("next_addr", imem_req_addr, nxt);
  endtask

  task automatic redirect_pulse(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_fault", out_fault, 0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_noreq", imem_req_valid, 0);
    step();

    // Back-to-back zero-wait fetches
    fetch(32'h8000_0000, 32'h0000_0093, 1'b0);
    fetch(32'h8000_0004, 32'h0000_0093, 1'b0);
    fetch(32'h8000_0008, 32'h0000_0093, 1'b0);

    // Decode stall in HOLD
    issue();
    respond(32'h0050_0113, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_pc", out_pc, 32'h8000_000C);
      chk("stall_inst", out_inst, 32'h0050_0113);
      chk("stall_noreq", imem_req_valid, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stall_next", imem_req_addr, 32'h8000_0010);

    // Redirect in WAIT, response two cycles later is dropped
    issue();
    redirect_pulse(32'h8000_0100);
    chk("flush_noreq", imem_req_valid, 0);
    step();
    respond(32'hBAD0_0001, 1'b0);
    chk("flush_noout", out_valid, 0);
    fetch(32'h8000_0100, 32'h0010_0093, 1'b0);

    // Redirect coincident with response in WAIT
    issue();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0002;
    redirect_pulse(32'h8000_0203);
    imem_rsp_valid = 1'b0;
    chk("coinc_noout", out_valid, 0);
    chk("coinc_req", imem_req_valid, 1);
    chk("coinc_addr", imem_req_addr, 32'h8000_0200);
    fetch(32'h8000_0200, 32'h0020_0093, 1'b0);

    // Redirect in REQ without, then with, acceptance
    redirect_pulse(32'h0000_0010);
    chk("req_rdr_valid", imem_req_valid, 1);
    chk("req_rdr_addr", imem_req_addr, 32'h0000_0010);
    imem_req_ready = 1'b1;
    redirect_pulse(32'h0000_0020);
    imem_req_ready = 1'b0;
    chk("req_rdr_flush", imem_req_valid, 0);
    respond(32'hBAD0_0003, 1'b0);
    chk("req_rdr_noout", out_valid, 0);
    chk("req_rdr_addr2", imem_req_addr, 32'h0000_0020);

    // Redirect in HOLD with same-cycle consume: pc takes redirect target
    issue();
    respond(32'h0030_0093, 1'b0);
    chk("hold_pc", out_pc, 32'h0000_0020);
    out_ready = 1'b1;
    redirect_pulse(32'hFFFF_FFFE);
    out_ready = 1'b0;
    chk("hold_rdr_drop", out_valid, 0);
    chk("hold_rdr_addr", imem_req_addr, 32'hFFFF_FFFC);

    // PC wrap and stray response in REQ
    fetch(32'hFFFF_FFFC, 32'h0040_0093, 1'b0);
    imem_rsp_valid = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    chk("stray_noout", out_valid, 0);
    chk("stray_addr", imem_req_addr, 32'h0);

    // Reset mid-WAIT
    issue();
    reset_n = 1'b0;
    #1;
    chk("midrst_req", imem_req_valid, 0);
    chk("midrst_out", out_valid, 0);
    step();
    reset_n = 1'b1;
    step();

    // Faulted fetch is delivered as NOP and fetching continues
    fetch(32'h8000_0000, 32'h0000_0093, 1'b0);
    fetch(32'h8000_0004, 32'h0000_0093, 1'b0);
    fetch(32'h8000_0008, 32'hDEAD_BEEF, 1'b1);
    fetch(32'h8000_000C, 32'h0000_0093, 1'b0);

    // Counter scenario: 10 handshakes, 2 discarded responses
    for (int i = 0; i < 6; i++) fetch(32'h8000_0010 + 32'(i * 4), 32'h0000_0093, 1'b0);
    issue();
    imem_rsp_valid = 1'b1;
    redirect_pulse(32'h8000_0400);
    imem_rsp_valid = 1'b0;
    issue();
    redirect_pulse(32'h8000_0500);
    respond(32'hBAD0_0004, 1'b0);
    chk("cnt_addr", imem_req_addr, 32'h8000_0500);
`ifdef YSYX_24090012_IFU_PERF_EN
    chk("fetch_cnt", fetch_cnt, 64'd10);
    chk("flush_cnt", {32'h0, flush_cnt}, 64'd2);
`endif
    issue();
    reset_n = 1'b0;
    #1;
`ifdef YSYX_24090012_IFU_PERF_EN
    chk("fetch_cnt_rst", fetch_cnt, 64'd0);
    chk("flush_cnt_rst", {32'h0, flush_cnt}, 64'd0);
`endif
    step();
    reset_n = 1'b1;
    step();
    chk("final_addr", imem_req_addr, 32'h8000_0000);
    chk("final_req", imem_req_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
